// File: rtl/cbm_neuron_fanout.sv
// Fan-out of CBM neuron-state beats to NOUT independently drained consumer buffers,
// each port seeing either the CBM state or the hidden state, tagged with frame-end.
module cbm_neuron_fanout #(
    parameter int unsigned     NH    = 8,
    parameter int unsigned     NOUT  = 3,
    parameter logic [NOUT-1:0] SEL   = 3'b110,
    parameter int unsigned     STEPS = 16,
    parameter string           BURST = "yes"
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic                   iValid_AS,
    output logic                   oReady_AS,
    input  logic [NH*3-1:0]        iData_AS,
    input  logic [NOUT-1:0]        iMask_AS,
    input  logic                   iFrameRst,
    output logic [NOUT-1:0]        oValid_BM,
    input  logic [NOUT-1:0]        iReady_BM,
    output logic [NOUT*NH*2-1:0]   oData_BM,
    output logic [NOUT-1:0]        oLast_BM
);

    localparam int unsigned   DEPTH   = (BURST == "yes") ? 2 : 1;
    localparam int unsigned   CW      = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned   PW      = 2 * NH;
    localparam logic [CW-1:0] CntLast = CW'(STEPS - 1);
    localparam logic [1:0]    DepthC  = 2'(DEPTH);

    logic [CW-1:0]   cnt_q, cnt_d, cnt_cur;
    logic            beat_last;
    logic            acc;
    logic [NOUT-1:0] full;

    // Ready depends only on registered fill levels and the mask, never on iReady_BM.
    assign oReady_AS = &(~iMask_AS | ~full);
    assign acc       = iValid_AS & oReady_AS;

    always_comb begin
        cnt_cur   = iFrameRst ? '0 : cnt_q;
        beat_last = (cnt_cur == CntLast);
        cnt_d     = cnt_q;
        if (acc) begin
            cnt_d = beat_last ? '0 : cnt_cur + CW'(1);
        end else if (iFrameRst) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar i = 0; i < NOUT; i++) begin : g_port
        logic [PW-1:0] payload;
        logic [PW:0]   in_ent;
        logic [PW:0]   ent0_q, ent0_d, ent1_q, ent1_d;
        logic [1:0]    fill_q, fill_d;
        logic          push, pop, valid;

        always_comb begin
            if (SEL[i]) begin
                payload = iData_AS[3*NH-1:NH];
            end else begin
                payload = {{NH{1'b0}}, iData_AS[NH-1:0]};
            end
        end

        assign in_ent  = {beat_last, payload};
        assign valid   = (fill_q != 2'd0);
        assign full[i] = (fill_q == DepthC);
        assign push    = acc & iMask_AS[i];
        assign pop     = valid & iReady_BM[i];

        // Head always lives in ent0; ent1 is only used in the 2-entry configuration.
        always_comb begin
            ent0_d = ent0_q;
            ent1_d = ent1_q;
            fill_d = fill_q;
            case ({push, pop})
                2'b10: begin
                    if (fill_q == 2'd0) begin
                        ent0_d = in_ent;
                    end else begin
                        ent1_d = in_ent;
                    end
                    fill_d = fill_q + 2'd1;
                end
                2'b01: begin
                    ent0_d = ent1_q;
                    fill_d = fill_q - 2'd1;
                end
                2'b11: begin
                    if (fill_q == 2'd1) begin
                        ent0_d = in_ent;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = in_ent;
                    end
                end
                default: begin
                end
            endcase
        end

        always_ff @(posedge iCLK or negedge iRST) begin
            if (!iRST) begin
                ent0_q <= '0;
                ent1_q <= '0;
                fill_q <= 2'd0;
            end else begin
                ent0_q <= ent0_d;
                ent1_q <= ent1_d;
                fill_q <= fill_d;
            end
        end

        assign oValid_BM[i]           = valid;
        assign oData_BM[i*PW +: PW]   = valid ? ent0_q[PW-1:0] : '0;
        assign oLast_BM[i]            = valid & ent0_q[PW];
    end

endmodule
